// File: rtl/score_encoder_pkg.sv
// Shared frame constants and state encoding for the score-frame
// producer and the argmax index decoder that consumes it.
package score_encoder_pkg;

  localparam int NUM_CLASS = 10;
  localparam int HDR_LEN   = 2;
  localparam int FRAME_LEN = HDR_LEN + NUM_CLASS + 1;
  localparam int SCORE_W   = 32;

  localparam int CNT_W =
    ($clog2(FRAME_LEN) > 5) ? $clog2(FRAME_LEN) : 5;
  localparam int IDX_W =
    (NUM_CLASS > 1) ? $clog2(NUM_CLASS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRAME = 2'd1,
    GAP   = 2'd2
  } state_e;

endpackage

// File: rtl/score_encoder_frame_counter.sv
// Frame word counter; phase flags and body offset describe the
// word that will be on the bus after the next clock edge.
module score_encoder_frame_counter
  import score_encoder_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             advance,
  output logic             hdr,
  output logic             body,
  output logic             tail,
  output logic             wrap,
  output logic [CNT_W-1:0] off
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign wrap = cnt_q == CNT_W'(FRAME_LEN - 1);

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = '0;
    end else if (advance) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end
  end

  assign hdr  = cnt_d < CNT_W'(HDR_LEN);
  assign body = !hdr &&
                cnt_d < CNT_W'(HDR_LEN + NUM_CLASS);
  assign tail = cnt_d == CNT_W'(FRAME_LEN - 1);
  assign off  = cnt_d - CNT_W'(HDR_LEN);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/score_encoder.sv
// Label-to-score-frame producer: one accepted class index becomes a
// one-hot framed word stream followed by a one-cycle gap.
module score_encoder
  import score_encoder_pkg::*;
#(
  parameter logic signed [SCORE_W-1:0] HIGH_VAL = 32'sd1,
  parameter logic signed [SCORE_W-1:0] LOW_VAL  = 32'sd0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      idx_valid,
  output logic                      idx_ready,
  input  logic [31:0]               idx_in,
  output logic                      en,
  output logic signed [SCORE_W-1:0] data_out,
  output logic                      last,
  output logic                      err,
  output logic                      busy
);

  state_e state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic ready_q, ready_d;
  logic en_q, en_d;
  logic signed [SCORE_W-1:0] data_q, data_d;
  logic last_q, last_d;
  logic err_q, err_d;
  logic busy_q, busy_d;

  logic start, advance;
  logic hdr, body, tail, wrap;
  logic [CNT_W-1:0] off;

  score_encoder_frame_counter u_cnt (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .advance (advance),
    .hdr     (hdr),
    .body    (body),
    .tail    (tail),
    .wrap    (wrap),
    .off     (off)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ready_d = 1'b0;
    en_d    = 1'b0;
    data_d  = '0;
    last_d  = 1'b0;
    err_d   = 1'b0;
    busy_d  = 1'b0;
    start   = 1'b0;
    advance = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (idx_valid) begin
          if (idx_in >= 32'(NUM_CLASS)) begin
            err_d = 1'b1;
          end else begin
            idx_d   = idx_in[IDX_W-1:0];
            start   = 1'b1;
            state_d = FRAME;
            ready_d = 1'b0;
            en_d    = 1'b1;
            busy_d  = 1'b1;
          end
        end
      end
      FRAME: begin
        advance = 1'b1;
        busy_d  = 1'b1;
        if (wrap) begin
          state_d = GAP;
        end else begin
          en_d = 1'b1;
        end
      end
      GAP: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
    // Word content follows the counter's next position.
    if (en_d) begin
      last_d = tail;
      if (!hdr && body) begin
        data_d = (off == CNT_W'(idx_d)) ? HIGH_VAL : LOW_VAL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ready_q <= 1'b1;
      en_q    <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ready_q <= ready_d;
      en_q    <= en_d;
      data_q  <= data_d;
      last_q  <= last_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign idx_ready = ready_q;
  assign en        = en_q;
  assign data_out  = data_q;
  assign last      = last_q;
  assign err       = err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_score_encoder.sv
// Directed bench for score_encoder: default one-hot instance plus a
// second instance with LOW_VAL=-5 / HIGH_VAL=100 sharing the inputs.
module tb_score_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        idx_valid = 1'b0;
  logic [31:0] idx_in = '0;

  logic               idx_ready, en, last, err, busy;
  logic signed [31:0] data_out;
  logic               idx_ready2, en2, last2, err2, busy2;
  logic signed [31:0] data_out2;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  score_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .idx_valid (idx_valid),
    .idx_ready (idx_ready),
    .idx_in    (idx_in),
    .en        (en),
    .data_out  (data_out),
    .last      (last),
    .err       (err),
    .busy      (busy)
  );

  score_encoder #(
    .HIGH_VAL (32'sd100),
    .LOW_VAL  (-32'sd5)
  ) dut2 (
    .clk       (clk),
    .rst       (rst),
    .idx_valid (idx_valid),
    .idx_ready (idx_ready2),
    .idx_in    (idx_in),
    .en        (en2),
    .data_out  (data_out2),
    .last      (last2),
    .err       (err2),
    .busy      (busy2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idx_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    n_assert++;
    if ({idx_ready, en, last, err, busy} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_flags: got rdy/en/last/err/busy=%b want 10000",
               {idx_ready, en, last, err, busy});
    end
    n_assert++;
    if (data_out !== 32'sd0) begin
      n_fail++;
      $display("FAIL reset_data: got %0d want 0", data_out);
    end
  endtask

  task automatic test_single_frame();
    logic signed [31:0] best_v;
    int best_i;
    logic signed [31:0] exp_d;
    best_v = 32'sh8000_0000;
    best_i = -1;
    idx_in = 32'd7;
    idx_valid = 1'b1;
    tick();
    idx_valid = 1'b0;
    for (int k = 0; k < 13; k++) begin
      exp_d = (k == 9) ? 32'sd1 : 32'sd0;
      n_assert++;
      if ({en, last, busy, idx_ready} !== {1'b1, k == 12, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL single_ctl[%0d]: got en/last/busy/rdy=%b want %b",
                 k, {en, last, busy, idx_ready},
                 {1'b1, k == 12, 1'b1, 1'b0});
      end
      n_assert++;
      if (data_out !== exp_d) begin
        n_fail++;
        $display("FAIL single_word[%0d]: got %0d want %0d", k, data_out, exp_d);
      end
      if (k >= 2 && k < 12 && data_out > best_v) begin
        best_v = data_out;
        best_i = k - 2;
      end
      tick();
    end
    n_assert++;
    if ({en, busy, idx_ready, last} !== 4'b0100 || data_out !== 32'sd0) begin
      n_fail++;
      $display("FAIL single_gap: got en/busy/rdy/last=%b data=%0d want 0100 data=0",
               {en, busy, idx_ready, last}, data_out);
    end
    n_assert++;
    if (best_i !== 7) begin
      n_fail++;
      $display("FAIL single_argmax: got %0d want 7", best_i);
    end
    tick();
    n_assert++;
    if ({idx_ready, busy, en} !== 3'b100) begin
      n_fail++;
      $display("FAIL single_idle: got rdy/busy/en=%b want 100",
               {idx_ready, busy, en});
    end
  endtask

  task automatic test_back_to_back();
    logic e_en, e_rdy, e_last;
    logic signed [31:0] e_d;
    int k;
    int id;
    idx_in = 32'd0;
    idx_valid = 1'b1;
    tick();
    idx_in = 32'd9;
    for (int c = 0; c <= 29; c++) begin
      e_en = 1'b0;
      e_d = 32'sd0;
      k = -1;
      id = 0;
      if (c <= 12) begin
        k = c;
        id = 0;
      end else if (c >= 15 && c <= 27) begin
        k = c - 15;
        id = 9;
      end
      e_rdy = (c == 14) || (c == 29);
      if (k >= 0) begin
        e_en = 1'b1;
        if (k - 2 == id && k >= 2 && k < 12) e_d = 32'sd1;
      end
      e_last = (k == 12);
      n_assert++;
      if ({en, idx_ready, last} !== {e_en, e_rdy, e_last} || data_out !== e_d) begin
        n_fail++;
        $display("FAIL b2b[%0d]: got en/rdy/last=%b data=%0d want %b data=%0d",
                 c, {en, idx_ready, last}, data_out,
                 {e_en, e_rdy, e_last}, e_d);
      end
      if (c == 15) idx_valid = 1'b0;
      if (c < 29) tick();
    end
  endtask

  task automatic test_bad_index();
    idx_in = 32'd10;
    idx_valid = 1'b1;
    tick();
    n_assert++;
    if ({err, en, idx_ready, busy} !== 4'b1010) begin
      n_fail++;
      $display("FAIL bad10: got err/en/rdy/busy=%b want 1010",
               {err, en, idx_ready, busy});
    end
    idx_in = 32'hFFFF_FFFF;
    tick();
    n_assert++;
    if ({err, en, idx_ready, busy} !== 4'b1010) begin
      n_fail++;
      $display("FAIL bad_max: got err/en/rdy/busy=%b want 1010",
               {err, en, idx_ready, busy});
    end
    idx_valid = 1'b0;
    tick();
    n_assert++;
    if ({err, en, idx_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL bad_after: got err/en/rdy=%b want 001",
               {err, en, idx_ready});
    end
  endtask

  task automatic test_mid_reset();
    logic signed [31:0] exp_d;
    idx_in = 32'd4;
    idx_valid = 1'b1;
    tick();
    idx_valid = 1'b0;
    repeat (6) tick();
    n_assert++;
    if (en !== 1'b1 || data_out !== 32'sd1) begin
      n_fail++;
      $display("FAIL mid_word6: got en=%b data=%0d want en=1 data=1",
               en, data_out);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_assert++;
    if ({en, busy, last, err, idx_ready} !== 5'b00001 || data_out !== 32'sd0) begin
      n_fail++;
      $display("FAIL mid_rst: got en/busy/last/err/rdy=%b data=%0d want 00001 data=0",
               {en, busy, last, err, idx_ready}, data_out);
    end
    idx_in = 32'd2;
    idx_valid = 1'b1;
    tick();
    idx_valid = 1'b0;
    for (int k = 0; k < 13; k++) begin
      exp_d = (k == 4) ? 32'sd1 : 32'sd0;
      n_assert++;
      if (en !== 1'b1 || last !== (k == 12) || data_out !== exp_d) begin
        n_fail++;
        $display("FAIL post_rst[%0d]: got en=%b last=%b data=%0d want en=1 last=%b data=%0d",
                 k, en, last, data_out, k == 12, exp_d);
      end
      tick();
    end
    n_assert++;
    if (en !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL post_rst_gap: got en=%b busy=%b want en=0 busy=1", en, busy);
    end
    tick();
  endtask

  task automatic test_custom_vals();
    logic signed [31:0] exp_d;
    idx_in = 32'd3;
    idx_valid = 1'b1;
    tick();
    idx_valid = 1'b0;
    for (int k = 0; k < 13; k++) begin
      if (k < 2 || k == 12) exp_d = 32'sd0;
      else if (k == 5) exp_d = 32'sd100;
      else exp_d = -32'sd5;
      n_assert++;
      if (en2 !== 1'b1 || last2 !== (k == 12) || data_out2 !== exp_d) begin
        n_fail++;
        $display("FAIL custom[%0d]: got en=%b last=%b data=%0d want en=1 last=%b data=%0d",
                 k, en2, last2, data_out2, k == 12, exp_d);
      end
      tick();
    end
    n_assert++;
    if (en2 !== 1'b0 || data_out2 !== 32'sd0) begin
      n_fail++;
      $display("FAIL custom_gap: got en=%b data=%0d want en=0 data=0",
               en2, data_out2);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_bad_index();
    test_mid_reset();
    test_custom_vals();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
